// File: rtl/powermod_par.sv
// Sequential modular exponentiator: res = (a^b) mod m, using right-to-left square-and-multiply.
// Optional macro POWERMOD_CHECK_EN enables the modulus-zero err flag; otherwise err is tied low.
module powermod_par #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] res,
    output logic         busy,
    output logic         rdy,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, INIT, LOOP, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   a_q, b_q, m_q, acc_q, res_q;
    logic           busy_q, rdy_q;
    logic [2*W-1:0] m_ext;
    logic [W-1:0]   a_mod_d, sq_d, mul_d, one_d;

    // Modulus forced non-zero so the divider never sees 0; the m=0 path never uses these values.
    always_comb begin
        m_ext   = {{W{1'b0}}, (m_q == '0) ? {{(W-1){1'b0}}, 1'b1} : m_q};
        a_mod_d = W'({{W{1'b0}}, a_q} % m_ext);
        sq_d    = W'(({{W{1'b0}}, a_q} * {{W{1'b0}}, a_q}) % m_ext);
        mul_d   = W'(({{W{1'b0}}, acc_q} * {{W{1'b0}}, a_q}) % m_ext);
        one_d   = (m_q == {{(W-1){1'b0}}, 1'b1}) ? '0 : {{(W-1){1'b0}}, 1'b1};
    end

`ifdef POWERMOD_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef POWERMOD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        m_q     <= m;
                        busy_q  <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
`ifdef POWERMOD_CHECK_EN
                    err_q <= (m_q == '0);
`endif
                    if (m_q == '0) begin
                        res_q   <= '0;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        a_q     <= a_mod_d;
                        acc_q   <= one_d;
                        state_q <= LOOP;
                    end
                end
                LOOP: begin
                    if (b_q != '0) begin
                        if (b_q[0]) acc_q <= mul_d;
                        a_q <= sq_d;
                        b_q <= b_q >> 1;
                    end else begin
                        // Result is published only on completion so res holds the previous answer meanwhile.
                        res_q   <= acc_q;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res  = res_q;
    assign busy = busy_q;
    assign rdy  = rdy_q;

endmodule

// File: tb/tb_powermod_par.sv
// Self-checking bench for powermod_par: directed and random operations on W=8 and W=16 instances
// against a repeated-multiplication reference model.
module tb_powermod_par;

    logic        clk = 1'b0;
    logic        rst_n, ena, start;
    logic [15:0] a_i, b_i, m_i;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic        busy8, rdy8, err8, busy16, rdy16, err16;
    logic        wide_sel;
    logic [15:0] res_s;
    logic        busy_s, rdy_s, err_s;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    powermod_par #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .a(a_i[7:0]), .b(b_i[7:0]), .m(m_i[7:0]),
        .res(res8), .busy(busy8), .rdy(rdy8), .err(err8)
    );

    powermod_par #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .a(a_i), .b(b_i), .m(m_i),
        .res(res16), .busy(busy16), .rdy(rdy16), .err(err16)
    );

    always_comb begin
        res_s  = wide_sel ? res16 : {8'h00, res8};
        busy_s = wide_sel ? busy16 : busy8;
        rdy_s  = wide_sel ? rdy16 : rdy8;
        err_s  = wide_sel ? err16 : err8;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_pow(input logic [15:0] x, input logic [15:0] e, input logic [15:0] md);
        longint r;
        if (md == 0) return 16'd0;
        r = 1 % longint'(md);
        for (int unsigned i = 0; i < e; i++) r = (r * longint'(x)) % longint'(md);
        return 16'(r);
    endfunction

    function automatic int bitlen(input logic [15:0] v);
        int n = 0;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy8 || busy16) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy8 || busy16) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic run_op(input string tag, input bit wide, input logic [15:0] ta, input logic [15:0] tb,
                          input logic [15:0] tm, input int off_at, input int off_len, input int restart_at);
        logic [15:0] ea, eb, em, exp_res;
        logic        exp_err;
        int          exp_cyc, rdy_first, rdy_cnt, busy_bad;
        ea = wide ? ta : {8'h00, ta[7:0]};
        eb = wide ? tb : {8'h00, tb[7:0]};
        em = wide ? tm : {8'h00, tm[7:0]};
        exp_res = ref_pow(ea, eb, em);
        exp_cyc = ((em == 0) ? 2 : bitlen(eb) + 3) + off_len;
`ifdef POWERMOD_CHECK_EN
        exp_err = (em == 0);
`else
        exp_err = 1'b0;
`endif
        wait_idle();
        wide_sel = wide;
        @(posedge clk); #1;
        a_i = ta; b_i = tb; m_i = tm; start = 1'b1; ena = 1'b1;
        rdy_first = -1; rdy_cnt = 0; busy_bad = 0;
        for (int c = 1; c <= exp_cyc + 2; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            if (c == restart_at) begin
                a_i = ~ta; b_i = 16'h00ff; m_i = tm + 16'd3;
            end
            ena = !(c >= off_at && c < off_at + off_len);
            if (rdy_s) begin
                rdy_cnt++;
                if (rdy_first < 0) rdy_first = c;
            end
            if (c <= exp_cyc && !busy_s) busy_bad++;
            if (c == exp_cyc + 2 && busy_s) busy_bad++;
        end
        start = 1'b0; ena = 1'b1;
        chk({tag, "_rdy_cycle"}, 32'(rdy_first), 32'(exp_cyc));
        chk({tag, "_rdy_count"}, 32'(rdy_cnt), 32'd1);
        chk({tag, "_res"}, {16'h0, res_s}, {16'h0, exp_res});
        chk({tag, "_err"}, {31'h0, err_s}, {31'h0, exp_err});
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int nrdy;
        logic [15:0] ra, rb, rm;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; wide_sel = 1'b0;
        a_i = '0; b_i = '0; m_i = '0;
        #12;
        chk("reset_res8", {24'h0, res8}, 32'd0);
        chk("reset_res16", {16'h0, res16}, 32'd0);
        chk("reset_flags", {28'h0, busy8, rdy8, busy16, rdy16}, 32'd0);
        chk("reset_err", {30'h0, err8, err16}, 32'd0);
        @(negedge clk); rst_n = 1'b1; ena = 1'b1;

        run_op("basic", 1'b0, 16'd4, 16'd13, 16'd211, 0, 0, -1);
        run_op("a_ge_m", 1'b0, 16'd250, 16'd2, 16'd7, 0, 0, -1);
        run_op("m_one", 1'b0, 16'd9, 16'd0, 16'd1, 0, 0, -1);
        run_op("b_zero", 1'b0, 16'd9, 16'd0, 16'd5, 0, 0, -1);
        run_op("m_zero", 1'b0, 16'd3, 16'd5, 16'd0, 0, 0, -1);
        run_op("w16_a", 1'b1, 16'd2, 16'd16, 16'd65535, 0, 0, -1);
        run_op("w16_b", 1'b1, 16'd65534, 16'd65535, 16'd65521, 0, 0, -1);
        run_op("ena_gap", 1'b0, 16'd4, 16'd13, 16'd211, 3, 3, -1);
        run_op("restart", 1'b0, 16'd4, 16'd13, 16'd211, 0, 0, 4);
        run_op("w8_max", 1'b0, 16'd255, 16'd255, 16'd255, 0, 0, -1);

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rm = 16'($urandom_range(0, 255));
            run_op("rand8", 1'b0, ra, rb, rm, 0, 0, -1);
        end
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rm = 16'($urandom);
            run_op("rand16", 1'b1, ra, rb, rm, 0, 0, -1);
        end

        // Reset during LOOP abandons the operation.
        wait_idle();
        wide_sel = 1'b0;
        @(posedge clk); #1;
        a_i = 16'd4; b_i = 16'd13; m_i = 16'd211; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_res", {16'h0, res_s}, 32'd0);
        chk("rst_mid_busy", {31'h0, busy_s}, 32'd0);
        chk("rst_mid_rdy", {31'h0, rdy_s}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        nrdy = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (rdy8 || rdy16 || busy8 || busy16) nrdy++;
        end
        chk("rst_no_rdy", 32'(nrdy), 32'd0);
        run_op("after_rst", 1'b0, 16'd2, 16'd3, 16'd5, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
